// File: rtl/spike_window_counter_if.sv
// spike_window_counter_if
//   Bundles the run/configuration inputs and the latched result outputs of
//   spike_window_counter. The host side uses the master modport and the
//   counter uses the slave modport.
//   Signals:
//     ena        host -> counter  run enable
//     spike_in   host -> counter  one spike line per channel
//     win_len    host -> counter  window length in cycles (0 acts as 1)
//     sel        host -> counter  channel select for count_out
//     count_out  counter -> host  latched count of channel sel
//     winner     counter -> host  lowest index holding the highest count
//     silent     counter -> host  every latched count is zero
//     valid      counter -> host  one-cycle pulse on a new result
interface spike_window_counter_if #(
   parameter int N_CH  = 8,
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
);
   localparam int SEL_W = $clog2(N_CH);

   logic              ena;
   logic [N_CH-1:0]   spike_in;
   logic [WIN_W-1:0]  win_len;
   logic [SEL_W-1:0]  sel;
   logic [CNT_W-1:0]  count_out;
   logic [SEL_W-1:0]  winner;
   logic              silent;
   logic              valid;

   modport master (
      output ena, spike_in, win_len, sel,
      input  count_out, winner, silent, valid
   );

   modport slave (
      input  ena, spike_in, win_len, sel,
      output count_out, winner, silent, valid
   );
endinterface

// File: rtl/spike_window_counter.sv
// spike_window_counter
//   Counts spike events per channel over back-to-back windows of win_len
//   cycles. At the end of each window the counts are copied to shadow
//   registers, the highest-count channel is flagged and valid pulses.
//   Dropping ena aborts the running window without touching latched results.
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    spike_window_counter_if.slave (ena, spike_in, win_len, sel in;
//            count_out, winner, silent, valid out)
//   Build option:
//     SPIKE_EDGE_DETECT_EN  count 0->1 transitions instead of high levels
//
//   state | meaning
//   IDLE  | not counting; first ena=1 cycle is cycle 0 of a window
//   COUNT | inside a window; wcnt holds cycles left including this one
module spike_window_counter #(
   parameter int N_CH  = 8,
   parameter int CNT_W = 8,
   parameter int WIN_W = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   spike_window_counter_if.slave bus
);
   localparam int SEL_W = $clog2(N_CH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {IDLE, COUNT} state_t;

   state_t            state_q, state_d;
   logic [WIN_W-1:0]  wcnt_q, wcnt_d;
   logic [WIN_W-1:0]  win_eff;
   logic [WIN_W-1:0]  rem;
   logic              last;
   logic              latch;

   logic [CNT_W-1:0]  cnt_q    [N_CH];
   logic [CNT_W-1:0]  cnt_nxt  [N_CH];
   logic [CNT_W-1:0]  shadow_q [N_CH];
   logic [CNT_W-1:0]  max_v;
   logic [SEL_W-1:0]  win_nxt;
   logic              sil_nxt;
   logic [SEL_W-1:0]  winner_q;
   logic              silent_q;
   logic              valid_q;
   logic [N_CH-1:0]   event_v;

`ifdef SPIKE_EDGE_DETECT_EN
   logic [N_CH-1:0]   hist_q;

   // History tracks the lines every cycle, whether or not a window runs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
      end else begin
         hist_q <= bus.spike_in;
      end
   end

   assign event_v = bus.spike_in & ~hist_q;
`else
   assign event_v = bus.spike_in;
`endif

   assign win_eff = (bus.win_len == '0) ? WIN_W'(1) : bus.win_len;
   // In IDLE the window has not been loaded yet, so the cycles left equal
   // the freshly sampled length; this lets a length-1 window end in cycle 0.
   assign rem  = (state_q == IDLE) ? win_eff : wcnt_q;
   assign last = bus.ena && (rem == WIN_W'(1));

   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         if (cnt_q[i] == CNT_MAX) begin
            cnt_nxt[i] = CNT_MAX;
         end else begin
            cnt_nxt[i] = cnt_q[i] + CNT_W'(event_v[i]);
         end
      end
   end

   // Strict greater-than keeps the lowest index on ties.
   always_comb begin
      max_v   = cnt_nxt[0];
      win_nxt = '0;
      for (int i = 1; i < N_CH; i++) begin
         if (cnt_nxt[i] > max_v) begin
            max_v   = cnt_nxt[i];
            win_nxt = SEL_W'(i);
         end
      end
      sil_nxt = (max_v == '0);
   end

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      latch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.ena) begin
               state_d = COUNT;
               latch   = last;
               wcnt_d  = last ? win_eff : win_eff - WIN_W'(1);
            end
         end
         COUNT: begin
            if (!bus.ena) begin
               state_d = IDLE;
               wcnt_d  = '0;
            end else if (last) begin
               latch  = 1'b1;
               wcnt_d = win_eff;
            end else begin
               wcnt_d = wcnt_q - WIN_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            wcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         wcnt_q   <= '0;
         winner_q <= '0;
         silent_q <= 1'b1;
         valid_q  <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            cnt_q[i]    <= '0;
            shadow_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         valid_q <= latch;
         for (int i = 0; i < N_CH; i++) begin
            if (!bus.ena || latch) begin
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_nxt[i];
            end
         end
         if (latch) begin
            winner_q <= win_nxt;
            silent_q <= sil_nxt;
            for (int i = 0; i < N_CH; i++) begin
               shadow_q[i] <= cnt_nxt[i];
            end
         end
      end
   end

   // Select values beyond N_CH-1 read as zero.
   always_comb begin
      bus.count_out = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (bus.sel == SEL_W'(i)) begin
            bus.count_out = shadow_q[i];
         end
      end
   end

   assign bus.winner = winner_q;
   assign bus.silent = silent_q;
   assign bus.valid  = valid_q;
endmodule

// File: tb/tb_spike_window_counter.sv
`timescale 1ns/1ps
module tb_spike_window_counter;
   localparam int N_CH  = 8;
   localparam int CNT_W = 8;
   localparam int WIN_W = 16;
   localparam int SEL_W = $clog2(N_CH);
   localparam int SAT   = (1 << CNT_W) - 1;

   logic clk;
   logic rst_n;

   spike_window_counter_if #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

   spike_window_counter #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
   endtask

   typedef struct {
      int cyc;
      int cnt [N_CH];
      int win;
      bit sil;
   } exp_t;

   exp_t exp_q[$];

   // Reference model: a window is W cycles long; position runs 0..W-1.
   bit              m_active;
   int              m_pos;
   int              m_len;
   int              m_cnt [N_CH];
   logic [N_CH-1:0] m_prev;

   function automatic int eff_len(input int wl);
      return (wl == 0) ? 1 : wl;
   endfunction

   task automatic model_reset();
      m_active = 0;
      m_pos    = 0;
      m_len    = 1;
      m_prev   = '0;
      for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
      exp_q.delete();
   endtask

   task automatic model_step();
      logic [N_CH-1:0] ev;
      exp_t e;
`ifdef SPIKE_EDGE_DETECT_EN
      ev = bus.spike_in & ~m_prev;
`else
      ev = bus.spike_in;
`endif
      if (bus.ena) begin
         if (!m_active) begin
            m_active = 1;
            m_pos    = 0;
            m_len    = eff_len(int'(bus.win_len));
         end
         for (int i = 0; i < N_CH; i++)
            if (ev[i]) m_cnt[i] = (m_cnt[i] + 1 > SAT) ? SAT : m_cnt[i] + 1;
         if (m_pos == m_len - 1) begin
            e.cyc = cyc + 1;
            e.win = 0;
            for (int i = 0; i < N_CH; i++) begin
               e.cnt[i] = m_cnt[i];
               if (m_cnt[i] > m_cnt[e.win]) e.win = i;
            end
            e.sil = (m_cnt[e.win] == 0);
            exp_q.push_back(e);
            for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
            m_pos = 0;
            m_len = eff_len(int'(bus.win_len));
         end else begin
            m_pos++;
         end
      end else begin
         m_active = 0;
         for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
      end
      m_prev = bus.spike_in;
   endtask

   task automatic drive(input bit e, input logic [7:0] s, input int wl);
      @(posedge clk);
      #2;
      bus.ena      = e;
      bus.spike_in = s[N_CH-1:0];
      bus.win_len  = WIN_W'(wl);
      model_step();
   endtask

   task automatic do_reset(input int n);
      @(posedge clk);
      #2;
      rst_n        = 1'b0;
      bus.ena      = 1'b0;
      bus.spike_in = '0;
      model_reset();
      repeat (n) @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_step();
   endtask

   // Monitor: compares latched outputs every cycle against the scoreboard.
   exp_t lat;
   initial begin
      lat.cyc = 0;
      lat.win = 0;
      lat.sil = 1;
      for (int i = 0; i < N_CH; i++) lat.cnt[i] = 0;
      forever begin
         bit ev;
         @(negedge clk);
         if (!rst_n) begin
            lat.win = 0;
            lat.sil = 1;
            for (int i = 0; i < N_CH; i++) lat.cnt[i] = 0;
            check("valid_in_reset", int'(bus.valid), 0);
            check("silent_in_reset", int'(bus.silent), 1);
            check("winner_in_reset", int'(bus.winner), 0);
            continue;
         end
         ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
         if (ev) lat = exp_q.pop_front();
         check("valid", int'(bus.valid), int'(ev));
         check("winner", int'(bus.winner), lat.win);
         check("silent", int'(bus.silent), int'(lat.sil));
         for (int ch = 0; ch < N_CH; ch++) begin
            bus.sel = SEL_W'(ch);
            #1;
            check($sformatf("count_out[%0d]", ch), int'(bus.count_out), lat.cnt[ch]);
         end
      end
   end

   initial begin
      rst_n        = 1'b0;
      bus.ena      = 1'b0;
      bus.spike_in = '0;
      bus.win_len  = '0;
      bus.sel      = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_step();

      // Level counting, length 4, channel 0 held high.
      repeat (13) drive(1, 8'h01, 4);
      repeat (2)  drive(0, 8'h00, 4);

      // Saturation over a 300-cycle window on channel 3.
      repeat (302) drive(1, 8'h08, 300);
      repeat (2)   drive(0, 8'h00, 300);

      // Tie between channels 2 and 5, channel 0 one behind.
      begin
         logic [7:0] pat [10];
         pat = '{8'h04, 8'h20, 8'h04, 8'h20, 8'h04, 8'h01, 8'h20, 8'h00, 8'h01, 8'h00};
         for (int k = 0; k < 10; k++) drive(1, pat[k], 10);
         repeat (2) drive(0, 8'h00, 10);
      end

      // Zero length behaves as one: valid every cycle, all silent.
      repeat (6) drive(1, 8'h00, 0);
      drive(1, 8'h12, 0);
      repeat (2) drive(0, 8'h00, 0);

      // Abort in cycle 5 of a length-8 window after earlier results.
      repeat (16) drive(1, 8'($urandom), 8);
      repeat (5)  drive(1, 8'($urandom), 8);
      repeat (3)  drive(0, 8'hff, 8);
      repeat (10) drive(1, 8'($urandom), 8);
      repeat (2)  drive(0, 8'h00, 8);

      // Channel 1 held high for 10 cycles in a 16-cycle window.
      repeat (10) drive(1, 8'h02, 16);
      repeat (6)  drive(1, 8'h00, 16);
      repeat (2)  drive(0, 8'h00, 16);

      // Reset in the middle of a window.
      repeat (4) drive(1, 8'($urandom), 10);
      do_reset(2);
      repeat (12) drive(1, 8'($urandom), 5);

      // Randomized traffic with changing lengths and occasional ena drops.
      for (int k = 0; k < 700; k++) begin
         bit   e;
         logic [7:0] s;
         e = ($urandom_range(0, 19) != 0);
         s = 8'($urandom) & 8'($urandom);
         drive(e, s, $urandom_range(0, 12));
      end

      repeat (3) drive(0, 8'h00, 4);
      @(negedge clk);
      #9;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/spike_window_counter.md
# spike_window_counter

Downstream readout stage for the LIF network: takes the per-neuron spike outputs and counts spike events on each channel over a programmable window of clock cycles. At the end of each window it latches all counts into shadow registers, flags the channel with the highest count, and pulses `valid`. Windows run back to back, so the host can sample spike rates without missing events.

## Interface
- `N_CH`, default 8: number of spike channels, between 2 and 8.
- `CNT_W`, default 8: width of each per-channel counter; counters saturate.
- `WIN_W`, default 16: width of the window-length input.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: run enable; low aborts or holds off counting.
- `spike_in` in N_CH: one spike line per neuron, synchronous to `clk`.
- `win_len` in WIN_W: window length in cycles; sampled at window start; value 0 is treated as 1.
- `sel` in clog2(N_CH): channel select for `count_out`.
- `count_out` out CNT_W: combinational mux of `shadow[sel]`.
- `winner` out clog2(N_CH): index of the channel with the highest latched count.
- `silent` out 1: high when every latched count is 0.
- `valid` out 1: one-cycle pulse when a new window result is latched.

## Operation
- Reset (async, `rst_n`=0):
  - Working counters, shadow registers, `winner`, `valid` and the window counter are cleared to 0.
  - `silent` is set to 1.
  - The edge-detect history register is cleared to 0.
  - The state goes to IDLE.
- State machine has two states, IDLE and COUNT.
- IDLE:
  - On a cycle with `ena`=1, load `wcnt` with max(`win_len`,1) and go to COUNT.
  - Spikes in this cycle are counted; it is the first cycle of the window.
- COUNT, each cycle:
  - For each channel with a spike event, `cnt[i]` = min(`cnt[i]`+1, 2^CNT_W−1).
  - `wcnt` decrements.
- Last window cycle (`wcnt`=1):
  - `shadow[i]` is loaded with that cycle's next-count value, so a spike on the last cycle is included.
  - Working counters clear to 0.
  - `wcnt` reloads from `win_len` (treating 0 as 1) and the block stays in COUNT.
  - `valid` is set for one cycle.
  - `winner` = lowest index among the channels with the maximum next-count.
  - `silent` = 1 if all next-counts are 0; `winner` is then 0.
- `ena` falling during COUNT:
  - The current window is aborted: working counters clear and the state returns to IDLE.
  - `shadow`, `winner` and `silent` hold; no `valid` pulse.
- `ena`=0 in IDLE: nothing changes; outputs hold their last latched values.
- Every spike event in a non-aborted window is counted exactly once; there is no gap cycle between windows.

## Timing
- A window of W cycles starts in cycle 0, the first `ena`=1 cycle in IDLE.
- `valid`, `shadow`, `winner` and `silent` update at the edge ending cycle W−1, so they are visible in cycle W.
- Results then repeat every W cycles while `ena` stays high.
- `count_out` follows `sel` combinationally, with zero cycles of latency from `shadow`.
- A new `win_len` value takes effect only at the next window reload.
- Reset asserted mid-window: everything clears immediately and no `valid` pulse is generated.

## Configuration
- `SPIKE_EDGE_DETECT_EN` defined:
  - A spike event is a 0→1 transition of `spike_in[i]` against a registered copy from the previous cycle.
  - A line held high counts once.
  - The history register keeps updating in IDLE and across window boundaries.
- Not defined: every cycle with `spike_in[i]`=1 is one event (level counting), and no history register is built.

## Test plan
1. Level mode, `win_len`=4, `spike_in`=0x01 held high from the first `ena` cycle → `valid` in cycle 4, `shadow[0]`=4, `winner`=0, `silent`=0; repeats every 4 cycles.
2. Saturation, CNT_W=8, `win_len`=300, `spike_in`=0x08 constant → `count_out` with `sel`=3 is 255, `winner`=3.
3. Tie: over `win_len`=10, channels 2 and 5 each get 3 single-cycle pulses, channel 0 gets 2 → `winner`=2, counts 3/3/2.
4. No spikes, `win_len`=0 → `valid` every cycle, all counts 0, `silent`=1, `winner`=0.
5. `ena` dropped in cycle 5 of a `win_len`=8 window after earlier results were latched → no `valid`; `shadow` and `winner` keep their prior values; counting restarts from 0 when `ena` returns.
6. With `SPIKE_EDGE_DETECT_EN`, channel 1 held high for 10 cycles in a `win_len`=16 window → count 1. Without the macro, the same stimulus gives a count of 10.
